// File: rtl/imm_field_encoder_pkg.sv
// Shared immediate-field types for the encoder and the decode-side sign extender.
package imm_pkg;

  localparam int unsigned IMM_W       = 32;
  localparam int unsigned IMM_FIELD_W = 26;
  localparam int unsigned IMM18_W     = 18;

  typedef enum logic {
    IMM_FMT26 = 1'b0,
    IMM_FMT18 = 1'b1
  } imm_src_e;

  typedef enum logic [1:0] {
    ENC_IDLE = 2'd0,
    ENC_HI   = 2'd1,
    ENC_LO   = 2'd2
  } enc_state_e;

  typedef struct packed {
    logic [IMM_FIELD_W-1:0] field;
    imm_src_e               src;
    logic                   hi;
    logic                   last;
    logic                   err;
  } enc_beat_t;

endpackage

// File: rtl/imm_field_encoder_if.sv
// Valid/ready stream bundle between the immediate source, the encoder and instruction memory.
interface imm_field_encoder_if #(
  parameter int unsigned ERR_CNT_W = 16
);

  logic                            in_valid;
  logic                            in_ready;
  logic [imm_pkg::IMM_W-1:0]       in_imm;
  logic                            in_src;
  logic                            out_valid;
  logic                            out_ready;
  logic [imm_pkg::IMM_FIELD_W-1:0] out_field;
  logic                            out_src;
  logic                            out_hi;
  logic                            out_last;
  logic                            out_err;
  logic [ERR_CNT_W-1:0]            err_cnt;

  modport slave (
    input  in_valid, in_imm, in_src, out_ready,
    output in_ready, out_valid, out_field, out_src, out_hi, out_last, out_err, err_cnt
  );

  modport master (
    output in_valid, in_imm, in_src, out_ready,
    input  in_ready, out_valid, out_field, out_src, out_hi, out_last, out_err, err_cnt
  );

endinterface

// File: rtl/imm_field_encoder_fit.sv
// Combinational range check and field packing of a 32-bit immediate for fmt 0 / fmt 1.
module imm_fit_check
  import imm_pkg::*;
(
  input  logic [IMM_W-1:0]       i_imm,
  input  logic                   i_fmt,
  output logic                   o_fits,
  output logic [IMM_FIELD_W-1:0] o_field
);

  logic w_fits26;
  logic w_fits18;

  // A value fits when every bit above the field's sign bit repeats that sign bit.
  assign w_fits26 = (&i_imm[IMM_W-1:IMM_FIELD_W-1]) | ~(|i_imm[IMM_W-1:IMM_FIELD_W-1]);
  assign w_fits18 = (&i_imm[IMM_W-1:IMM18_W-1])     | ~(|i_imm[IMM_W-1:IMM18_W-1]);

  always_comb begin
    o_fits  = w_fits26;
    o_field = i_imm[IMM_FIELD_W-1:0];
    if (imm_src_e'(i_fmt) == IMM_FMT18) begin
      o_fits  = w_fits18;
      o_field = IMM_FIELD_W'(i_imm[IMM18_W-1:0]);
    end
  end

endmodule

// File: rtl/imm_field_encoder.sv
// Registered immediate-field encoder with range checking and saturating error count.
// IMM_SPLIT_EN: emit oversize values as HI/LO fmt1 beats instead of a truncated error beat.
module imm_field_encoder
  import imm_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
`ifdef IMM_SPLIT_EN
  , parameter int unsigned SPLIT_SHIFT = 14
`endif
) (
  input logic                clk,
  input logic                rst,
  imm_field_encoder_if.slave bus
);

  logic                   w_fits;
  logic [IMM_FIELD_W-1:0] w_field;

  enc_state_e             r_state;
  enc_state_e             w_state_nxt;
  enc_beat_t              r_beat;
  enc_beat_t              w_beat_nxt;
  logic                   r_valid;
  logic                   w_valid_nxt;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_take;

`ifdef IMM_SPLIT_EN
  logic [SPLIT_SHIFT-1:0] r_lo;
  logic [SPLIT_SHIFT-1:0] w_lo_nxt;
  logic [IMM18_W-1:0]     w_hi_part;

  assign w_hi_part = IMM18_W'(bus.in_imm >> SPLIT_SHIFT);
`endif

  imm_fit_check u_fit (
    .i_imm   (bus.in_imm),
    .i_fmt   (bus.in_src),
    .o_fits  (w_fits),
    .o_field (w_field)
  );

  assign w_in_ready = (r_state == ENC_IDLE) && (!r_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_take     = r_valid && bus.out_ready;

  // Next-state and next-beat selection.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_valid_nxt = r_valid;
`ifdef IMM_SPLIT_EN
    w_lo_nxt    = r_lo;
`endif
    case (r_state)
      ENC_IDLE: begin
        if (w_accept) begin
          w_valid_nxt     = 1'b1;
          w_beat_nxt.field = w_field;
          w_beat_nxt.src  = imm_src_e'(bus.in_src);
          w_beat_nxt.hi   = 1'b0;
          w_beat_nxt.last = 1'b1;
          w_beat_nxt.err  = !w_fits;
`ifdef IMM_SPLIT_EN
          if (!w_fits) begin
            w_beat_nxt.field = IMM_FIELD_W'(w_hi_part);
            w_beat_nxt.src   = IMM_FMT18;
            w_beat_nxt.hi    = 1'b1;
            w_beat_nxt.last  = 1'b0;
            w_beat_nxt.err   = 1'b0;
            w_lo_nxt         = bus.in_imm[SPLIT_SHIFT-1:0];
            w_state_nxt      = ENC_HI;
          end
`endif
        end else if (w_take) begin
          w_valid_nxt = 1'b0;
        end
      end
`ifdef IMM_SPLIT_EN
      ENC_HI: begin
        if (w_take) begin
          w_beat_nxt.field = IMM_FIELD_W'(r_lo);
          w_beat_nxt.hi    = 1'b0;
          w_beat_nxt.last  = 1'b1;
          w_state_nxt      = ENC_LO;
        end
      end
      ENC_LO: begin
        if (w_take) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ENC_IDLE;
        end
      end
`endif
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = ENC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ENC_IDLE;
      r_valid <= 1'b0;
      r_beat  <= '0;
`ifdef IMM_SPLIT_EN
      r_lo    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_beat  <= w_beat_nxt;
`ifdef IMM_SPLIT_EN
      r_lo    <= w_lo_nxt;
`endif
    end
  end

  // Counts accepted values that did not fit their requested format.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_accept && !w_fits && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_field = r_beat.field;
  assign bus.out_src   = r_beat.src;
  assign bus.out_hi    = r_beat.hi;
  assign bus.out_last  = r_beat.last;
  assign bus.out_err   = r_beat.err;
  assign bus.err_cnt   = r_err_cnt;

endmodule
